// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline hazard controller. Detects load-use hazards, handles
//            branch/jump flushes and memory-busy freezes, drains the pipe on
//            stop, and keeps saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        start,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        mem_busy,
  output logic        pc_wr,
  output logic        ifid_wr,
  output logic        nop,
  output logic        ifid_flush,
  output logic        pipe_en,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] run_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [1:0]  DRAIN_LAST = 2'd2;   // third DRAIN cycle
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  state_t     cur_state;
  state_t     nxt_state;
  logic [1:0] drain_cnt;
  logic       hazard;
  logic       redirect;
  logic       stall_inc;
  logic       flush_inc;
  logic       run_inc;

  // Load-use hazard: the EX load writes a register the ID instruction reads.
  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign hazard = ex_memread && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign redirect  = branch_taken || jump;
  assign run_inc   = (cur_state == RUN);
  assign stall_inc = run_inc && hazard;
  // A stall wins over a redirect: the redirecting instruction is re-presented
  // after the bubble, so flushing now would lose it.
  assign flush_inc = run_inc && !hazard && redirect;

  assign state = cur_state;

  // State register and drain-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= IDLE;
      drain_cnt <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      if ((cur_state == DRAIN) && (nxt_state == DRAIN)) begin
        drain_cnt <= drain_cnt + 2'd1;
      end else begin
        drain_cnt <= 2'd0;
      end
    end
  end

  // Next-state and per-state pipeline control outputs.
  always_comb begin
    nxt_state  = cur_state;
    pc_wr      = 1'b0;
    ifid_wr    = 1'b0;
    nop        = 1'b1;
    ifid_flush = 1'b0;
    pipe_en    = 1'b1;
    case (cur_state)
      IDLE: begin
        if (start) begin
          nxt_state = RUN;
        end
      end
      RUN: begin
        if (hazard) begin
          pc_wr   = 1'b0;
          ifid_wr = 1'b0;
          nop     = 1'b1;
        end else begin
          pc_wr      = 1'b1;
          ifid_wr    = 1'b1;
          nop        = 1'b0;
          ifid_flush = redirect;
        end
        // A busy memory must be waited out before stopping.
        if (mem_busy) begin
          nxt_state = HOLD;
        end else if (!start) begin
          nxt_state = DRAIN;
        end
      end
      HOLD: begin
        nop     = 1'b0;
        pipe_en = 1'b0;
        if (!mem_busy) begin
          nxt_state = start ? RUN : DRAIN;
        end
      end
      DRAIN: begin
        ifid_flush = 1'b1;
        // start and mem_busy are deliberately ignored while draining.
        if (drain_cnt == DRAIN_LAST) begin
          nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
      run_cnt   <= 32'd0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_inc && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
      if (run_inc && (run_cnt != CNT_MAX)) begin
        run_cnt <= run_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios with
//            literal expectations plus randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        jump;
  logic        mem_busy;
  logic        pc_wr;
  logic        ifid_wr;
  logic        nop;
  logic        ifid_flush;
  logic        pipe_en;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] run_cnt;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0=idle 1=run 2=hold 3=drain, with cycles left in drain.
  int          m_mode;
  int          m_left;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  logic [31:0] m_run;
  bit          cmp_en = 1'b0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .mem_busy     (mem_busy),
    .pc_wr        (pc_wr),
    .ifid_wr      (ifid_wr),
    .nop          (nop),
    .ifid_flush   (ifid_flush),
    .pipe_en      (pipe_en),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .run_cnt      (run_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hazard();
    return ex_memread && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_left  = 0;
    m_stall = 0;
    m_flush = 0;
    m_run   = 0;
  endtask

  // Asynchronous reset seen by the model immediately.
  always @(negedge rst) model_reset();

  // Model advance at each rising edge, from the rules of each mode.
  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      model_reset();
    end else begin
      case (m_mode)
        0: if (start) m_mode = 1;
        1: begin
          m_run = sat_inc(m_run);
          if (is_hazard()) m_stall = sat_inc(m_stall);
          else if (branch_taken || jump) m_flush = sat_inc(m_flush);
          if (mem_busy) m_mode = 2;
          else if (!start) begin m_mode = 3; m_left = 3; end
        end
        2: if (!mem_busy) begin
          if (start) m_mode = 1;
          else begin m_mode = 3; m_left = 3; end
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 0;
        end
      endcase
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (cmp_en && rst === 1'b1) begin
      logic [4:0] e;  // {pc_wr, ifid_wr, nop, ifid_flush, pipe_en}
      case (m_mode)
        0: e = 5'b00101;
        1: if (is_hazard()) e = 5'b00101;
           else e = {3'b110, (branch_taken || jump), 1'b1};
        2: e = 5'b00000;
        default: e = 5'b00111;
      endcase
      chk("m_state",      {30'd0, state}, m_mode[31:0]);
      chk("m_pc_wr",      {31'd0, pc_wr},      {31'd0, e[4]});
      chk("m_ifid_wr",    {31'd0, ifid_wr},    {31'd0, e[3]});
      chk("m_nop",        {31'd0, nop},        {31'd0, e[2]});
      chk("m_ifid_flush", {31'd0, ifid_flush}, {31'd0, e[1]});
      chk("m_pipe_en",    {31'd0, pipe_en},    {31'd0, e[0]});
      chk("m_stall_cnt",  stall_cnt, m_stall);
      chk("m_flush_cnt",  flush_cnt, m_flush);
      chk("m_run_cnt",    run_cnt,   m_run);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rt = 0;
    branch_taken = 0; jump = 0; mem_busy = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rt);
    ex_memread = 1; ex_rt = rt; id_rs = 8; id_rt = 0; id_uses_rt = 0;
  endtask

  initial begin
    logic [31:0] rc;
    rst = 1'b0;
    start = 1'b0;
    clr_in();
    model_reset();
    repeat (2) tick();
    // Reset state
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_pc_wr", {31'd0, pc_wr}, 0);
    chk("rst_nop", {31'd0, nop}, 1);
    chk("rst_pipe_en", {31'd0, pipe_en}, 1);
    chk("rst_run_cnt", run_cnt, 0);
    rst = 1'b1;
    cmp_en = 1'b1;
    tick();
    chk("idle_hold", {30'd0, state}, 0);

    // Start: one IDLE edge, then RUN
    start = 1'b1;
    #1 chk("idle_before_start_edge", {30'd0, state}, 0);
    tick();
    chk("run_entered", {30'd0, state}, 1);
    chk("run_pc_wr", {31'd0, pc_wr}, 1);
    chk("run_ifid_wr", {31'd0, ifid_wr}, 1);
    repeat (5) tick();
    chk("run_cnt_5", run_cnt, 5);

    // Load-use stall, then the same with ex_rt=0
    set_load_use(8);
    #1;
    chk("stall_pc_wr", {31'd0, pc_wr}, 0);
    chk("stall_ifid_wr", {31'd0, ifid_wr}, 0);
    chk("stall_nop", {31'd0, nop}, 1);
    tick();
    chk("stall_cnt_1", stall_cnt, 1);
    set_load_use(0);
    id_rs = 0;
    #1 chk("r0_no_stall_pc_wr", {31'd0, pc_wr}, 1);
    tick();
    chk("r0_stall_cnt", stall_cnt, 1);

    // Stall beats branch; then branch alone flushes
    set_load_use(8);
    branch_taken = 1;
    #1 chk("prio_no_flush", {31'd0, ifid_flush}, 0);
    tick();
    chk("prio_flush_cnt", flush_cnt, 0);
    chk("prio_stall_cnt", stall_cnt, 2);
    ex_memread = 0;
    #1 chk("br_flush", {31'd0, ifid_flush}, 1);
    tick();
    chk("br_flush_cnt", flush_cnt, 1);
    clr_in();

    // mem_busy for 4 cycles -> 4 HOLD cycles, frozen counters
    mem_busy = 1;
    tick();
    rc = run_cnt;
    chk("hold_run_cnt", rc, 10);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_state", {30'd0, state}, 2);
      chk("hold_pipe_en", {31'd0, pipe_en}, 0);
      chk("hold_frozen", run_cnt, 10);
      if (i == 3) mem_busy = 0;
      tick();
    end
    chk("hold_back_run", {30'd0, state}, 1);

    // Drain: exactly 3 cycles even with start=1
    start = 0;
    tick();
    start = 1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_state", {30'd0, state}, 3);
      chk("drain_flush", {31'd0, ifid_flush}, 1);
      tick();
    end
    chk("drain_to_idle", {30'd0, state}, 0);
    tick();
    chk("idle_to_run", {30'd0, state}, 1);

    // Asynchronous reset mid-DRAIN
    start = 0;
    tick();
    tick();
    chk("pre_rst_drain", {30'd0, state}, 3);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, state}, 0);
    chk("async_rst_run_cnt", run_cnt, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    chk("async_rst_flush_cnt", flush_cnt, 0);
    chk("async_rst_nop", {31'd0, nop}, 1);
    #1 rst = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_idle", {30'd0, state}, 0);
    end
    start = 1;
    tick();
    tick();

    // Saturation of stall_cnt
    force dut.stall_cnt = 32'hFFFF_FFFE;
    m_stall = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cnt;
    set_load_use(8);
    repeat (3) tick();
    chk("stall_saturated", stall_cnt, 32'hFFFF_FFFF);
    clr_in();
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      start        = ($urandom_range(0, 99) < 90);
      mem_busy     = ($urandom_range(0, 99) < 15);
      ex_memread   = ($urandom_range(0, 99) < 35);
      ex_rt        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 99) < 15);
      jump         = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: level run request from the bench or host.
REQ-004 SHALL have ports id_rs, id_rt, input, 5 each: source registers of the instruction in ID.
REQ-005 SHALL have port id_uses_rt, input, 1: the ID instruction reads rt as a source.
REQ-006 SHALL have ports ex_memread, input, 1, and ex_rt, input, 5: the EX instruction is a load and writes rt.
REQ-007 SHALL have port branch_taken, input, 1: branch resolved taken in ID.
REQ-008 SHALL have port jump, input, 1: jump decoded in ID.
REQ-009 SHALL have port mem_busy, input, 1: the data memory needs another cycle.
REQ-010 SHALL have port pc_wr, output, 1: PC register write enable.
REQ-011 SHALL have port ifid_wr, output, 1: IF/ID register write enable.
REQ-012 SHALL have port nop, output, 1: zero the ID/EX control fields (bubble).
REQ-013 SHALL have port ifid_flush, output, 1: clear IF/ID to a NOP.
REQ-014 SHALL have port pipe_en, output, 1: enable for ID/EX, EX/MEM and MEM/WB registers.
REQ-015 SHALL have ports stall_cnt, flush_cnt and run_cnt, output, 32 each: performance counters.
REQ-016 SHALL have port state, output, 2: IDLE=00, RUN=01, HOLD=10, DRAIN=11.

Function
REQ-017 IDLE SHALL drive pc_wr=0, ifid_wr=0, nop=1, ifid_flush=0, pipe_en=1.
REQ-018 IDLE SHALL go to RUN on the edge where start=1.
REQ-019 A load-use hazard SHALL be: ex_memread=1, ex_rt!=0, and either ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
REQ-020 In RUN with a hazard, the block SHALL combinationally drive pc_wr=0, ifid_wr=0, nop=1, ifid_flush=0, and increment stall_cnt at the edge.
REQ-021 In RUN without a hazard and with branch_taken or jump, the block SHALL drive pc_wr=1, ifid_wr=1, nop=0, ifid_flush=1, and increment flush_cnt at the edge.
REQ-022 A hazard SHALL take priority over branch_taken or jump in the same cycle; no flush and no flush_cnt increment.
REQ-023 In RUN otherwise, the block SHALL drive pc_wr=1, ifid_wr=1, nop=0, ifid_flush=0, pipe_en=1.
REQ-024 run_cnt SHALL increment on every edge spent in RUN.
REQ-025 mem_busy=1 in RUN SHALL move the block to HOLD at the next edge.
REQ-026 Hazard and flush outputs and counters SHALL still apply in that RUN cycle.
REQ-027 HOLD SHALL drive pc_wr=0, ifid_wr=0, nop=0, ifid_flush=0, pipe_en=0, freezing the whole pipeline.
REQ-028 HOLD SHALL leave all counters unchanged.
REQ-029 HOLD SHALL return to RUN at the edge where mem_busy=0 and start=1.
REQ-030 HOLD SHALL go to DRAIN at the edge where mem_busy=0 and start=0.
REQ-031 start=0 in RUN with mem_busy=0 SHALL move the block to DRAIN at the next edge.
REQ-032 DRAIN SHALL drive pc_wr=0, ifid_wr=0, ifid_flush=1, nop=1, pipe_en=1 for exactly 3 cycles, using an internal 2-bit counter, then go to IDLE.
REQ-033 start in DRAIN SHALL be ignored; re-entry to RUN SHALL always pass through IDLE, giving a minimum 3 DRAIN + 1 IDLE cycles.
REQ-034 mem_busy in DRAIN SHALL be ignored.
REQ-035 All counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-036 The hazard compare SHALL ignore register 0; ex_rt=0 never stalls.

Reset
REQ-037 rst=0 SHALL immediately force state=IDLE, clear all counters and the drain counter, and drive the IDLE output values, regardless of clock.
REQ-038 Reset asserted mid-RUN, HOLD or DRAIN SHALL take effect the same way.
REQ-039 After rst rises, the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-040 Reset, then start=1 -> IDLE for 1 edge, then RUN with pc_wr=1, ifid_wr=1; run_cnt=5 after 5 RUN edges.
REQ-041 RUN with ex_memread=1, ex_rt=8, id_rs=8 for 1 cycle -> pc_wr=0, ifid_wr=0, nop=1 that cycle; stall_cnt=1. Same stimulus with ex_rt=0 -> no stall.
REQ-042 Load-use hazard with branch_taken=1 in the same cycle -> stall only, ifid_flush=0, flush_cnt unchanged. Next cycle branch_taken=1 with no hazard -> ifid_flush=1, flush_cnt=1.
REQ-043 mem_busy=1 for 4 cycles in RUN -> state=HOLD for 4 cycles with pipe_en=0 and counters frozen, then back to RUN.
REQ-044 start=0 in RUN -> DRAIN for exactly 3 cycles with ifid_flush=1, then IDLE; start=1 during DRAIN does not shorten it. rst=0 pulsed mid-DRAIN -> IDLE and zero counters asynchronously.
REQ-045 Force stall_cnt to 0xFFFFFFFE, then apply 3 hazard cycles -> stall_cnt holds 0xFFFFFFFF.
